// File: rtl/ucie_ctl_retrain_seq_if.sv
// Retrain sequencer bundle: CSR retrain level and PHY-mirror write in, RDI request and CSR adapter write out.
// The slave side is the sequencer and the master side is the CSR/RDI environment.
interface ucie_ctl_retrain_seq_if;
  logic        i_retrain;
  logic        i_phy_WR;
  logic [7:0]  i_phy_addr;
  logic [31:0] i_phy_WDATA;
  logic [4:0]  i_pl_state_sts;
  logic [4:0]  o_lp_state_req;
  logic        o_A_Valid;
  logic [7:0]  o_A_addr;
  logic [31:0] o_A_WDATA;
  logic        o_retrain_busy;
  logic        o_retrain_timeout;

  modport master (
    output i_retrain, i_phy_WR, i_phy_addr, i_phy_WDATA, i_pl_state_sts,
    input  o_lp_state_req, o_A_Valid, o_A_addr, o_A_WDATA, o_retrain_busy, o_retrain_timeout
  );

  modport slave (
    input  i_retrain, i_phy_WR, i_phy_addr, i_phy_WDATA, i_pl_state_sts,
    output o_lp_state_req, o_A_Valid, o_A_addr, o_A_WDATA, o_retrain_busy, o_retrain_timeout
  );
endinterface

// File: rtl/ucie_ctl_retrain_seq.sv
// Retrain sequencer: drives RDI Retrain then Active, then clears the CSR retrain bit; request is 1 cycle after i_retrain,
// CSR write pulses the cycle after CLEAR; no backpressure, waits on status with a bounded counter that aborts on timeout.
module ucie_ctl_retrain_seq #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [4:0]  RETRAIN_STATE  = 5'b01011,
  parameter logic [4:0]  ACTIVE_STATE   = 5'b00001,
  parameter logic [4:0]  NOP_STATE      = 5'b00000
) (
  input logic                   i_clk,
  input logic                   i_rst_n,
  ucie_ctl_retrain_seq_if.slave bus
);
  localparam int unsigned   CW          = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LIMIT   = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    CTL_ADDR    = 8'h10;
  localparam int unsigned   RETRAIN_BIT = 11;

  typedef enum logic [2:0] {IDLE, REQ, WAIT_ACTIVE, CLEAR, COOLDOWN} state_t;

  state_t      state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic        cd_last, cd_last_nxt;
  logic [31:0] ctl_shadow;
  logic [31:0] shadow_src;
  logic        shadow_load;
  logic        at_limit;
  logic [4:0]  lp_req;
  logic        a_vld, a_vld_nxt;
  logic [7:0]  a_addr, a_addr_nxt;
  logic [31:0] a_wdata, a_wdata_nxt;
  logic        timeout, timeout_nxt;

  assign shadow_load = bus.i_phy_WR && (bus.i_phy_addr == CTL_ADDR);
  // A write landing in the CLEAR cycle must not be lost to the stale shadow.
  assign shadow_src  = shadow_load ? bus.i_phy_WDATA : ctl_shadow;
  assign at_limit    = (cnt == CNT_LIMIT);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    cd_last_nxt = cd_last;
    lp_req      = NOP_STATE;
    a_vld_nxt   = 1'b0;
    a_addr_nxt  = 8'h00;
    a_wdata_nxt = 32'h0;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (bus.i_retrain) begin
          state_nxt = REQ;
          cnt_nxt   = '0;
        end
      end
      REQ: begin
        lp_req  = RETRAIN_STATE;
        cnt_nxt = cnt + 1'b1;
        if (bus.i_pl_state_sts == RETRAIN_STATE) begin
          state_nxt = WAIT_ACTIVE;
        end else if (at_limit) begin
          timeout_nxt = 1'b1;
          state_nxt   = CLEAR;
        end
      end
      WAIT_ACTIVE: begin
        lp_req  = ACTIVE_STATE;
        cnt_nxt = cnt + 1'b1;
        if (bus.i_pl_state_sts == ACTIVE_STATE) begin
          state_nxt = CLEAR;
        end else if (at_limit) begin
          timeout_nxt = 1'b1;
          state_nxt   = CLEAR;
        end
      end
      CLEAR: begin
        a_vld_nxt              = 1'b1;
        a_addr_nxt             = CTL_ADDR;
        a_wdata_nxt            = shadow_src;
        a_wdata_nxt[RETRAIN_BIT] = 1'b0;
        cd_last_nxt            = 1'b0;
        state_nxt              = COOLDOWN;
      end
      COOLDOWN: begin
        // Two cycles so a CSR write deferred by a collision still lands first.
        cd_last_nxt = 1'b1;
        if (cd_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      cd_last    <= 1'b0;
      ctl_shadow <= 32'h0;
      a_vld      <= 1'b0;
      a_addr     <= 8'h00;
      a_wdata    <= 32'h0;
      timeout    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      cd_last <= cd_last_nxt;
      if (shadow_load) ctl_shadow <= bus.i_phy_WDATA;
      a_vld   <= a_vld_nxt;
      a_addr  <= a_addr_nxt;
      a_wdata <= a_wdata_nxt;
      timeout <= timeout_nxt;
    end
  end

  assign bus.o_lp_state_req    = lp_req;
  assign bus.o_A_Valid         = a_vld;
  assign bus.o_A_addr          = a_addr;
  assign bus.o_A_WDATA         = a_wdata;
  assign bus.o_retrain_busy    = (state != IDLE);
  assign bus.o_retrain_timeout = timeout;
endmodule
